ysyx_24100005_wb_queue: RTL and testbench

Writeback queue that feeds the write port of the integer register file. It accepts results from the ALU and the LSU over valid/ready handshakes, arbitrates between them, and buffers them in a small in-order FIFO. It drains one entry per cycle into the register file's `wen`/`waddr`/`wdata` port. It also reports which architectural registers still have a pending write, for hazard checks in decode.

---
 rtl/ysyx_24100005_wb_queue.sv | 141 ++++++++++++++
 tb/tb_ysyx_24100005_wb_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_wb_queue.sv
// Writeback queue: arbitrates ALU/LSU results into an in-order FIFO that drains
// one entry per cycle into the register file write port, and reports pending
// destination registers for decode hazard checks.
module ysyx_24100005_wb_queue #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_WIDTH-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,

    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_rd,
    input  logic [DATA_WIDTH-1:0]   lsu_data,

    output logic                    rf_wen,
    output logic [ADDR_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0]   rf_wdata,

    input  logic [ADDR_WIDTH-1:0]   chk_rs1,
    input  logic [ADDR_WIDTH-1:0]   chk_rs2,
    output logic                    busy_rs1,
    output logic                    busy_rs2,

    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] rd_mem_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] rd_mem_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];

    logic [PTR_W-1:0] rp_q, rp_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_rd;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DEPTH-1:0]      occupied;

    // Fixed-priority arbitration (LSU wins); full is judged before this cycle's pop.
    always_comb begin
        full      = (cnt_q == CNT_W'(DEPTH));
        empty     = (cnt_q == '0);
        lsu_ready = lsu_valid & ~full;
        alu_ready = alu_valid & ~full & ~lsu_valid;
        push_rd   = lsu_valid ? lsu_rd   : alu_rd;
        push_data = lsu_valid ? lsu_data : alu_data;
        // x0 results complete the handshake but are dropped.
        push      = (lsu_ready | alu_ready) & (push_rd != '0);
        pop       = ~empty;
    end

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        rp_d       = rp_q;
        wp_d       = wp_q;
        cnt_d      = cnt_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            rd_mem_d[wp_q]   = push_rd;
            data_mem_d[wp_q] = push_data;
            wp_d             = wp_q + PTR_W'(1);
        end
        if (pop) begin
            rp_d = rp_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state, cleared asynchronously so pending entries are discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        rd_mem_q   <= rd_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Head entry drives the register file write port; zeros when empty.
    always_comb begin
        rf_wen   = ~empty;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!empty) begin
            rf_waddr = rd_mem_q[rp_q];
            rf_wdata = data_mem_q[rp_q];
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = (CNT_W'(PTR_W'(i) - rp_q) < cnt_q);
        end
    end

    // Pending-write lookup over live slots only; x0 is never busy.
    always_comb begin
        busy_rs1 = 1'b0;
        busy_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (rd_mem_q[i] == chk_rs1)) busy_rs1 = 1'b1;
            if (occupied[i] && (rd_mem_q[i] == chk_rs2)) busy_rs2 = 1'b1;
        end
        if (chk_rs1 == '0) busy_rs1 = 1'b0;
        if (chk_rs2 == '0) busy_rs2 = 1'b0;
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_ysyx_24100005_wb_queue.sv
// Scoreboard bench: the driver pushes accepted results into an expected queue,
// an independent monitor pops and compares at every falling edge.
module tb_ysyx_24100005_wb_queue;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, lsu_valid;
    logic          alu_ready, lsu_ready;
    logic [AW-1:0] alu_rd, lsu_rd;
    logic [DW-1:0] alu_data, lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] chk_rs1, chk_rs2;
    logic          busy_rs1, busy_rs2;
    logic [$clog2(DEPTH):0] count;

    ent_t          exp_q[$];
    int            model_cnt;
    int            n_cmp;
    int            n_fail;
    logic [AW-1:0] last_rd;

    ysyx_24100005_wb_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: compares the visible state against pending writes, then retires the head.
    always @(negedge clk) begin
        if (rst) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("busy_rs1", 64'(busy_rs1), 64'(model_busy(chk_rs1)));
            chk("busy_rs2", 64'(busy_rs2), 64'(model_busy(chk_rs2)));
            model_cnt = exp_q.size();
            if (exp_q.size() > 0) begin
                chk("rf_wen", 64'(rf_wen), 64'd1);
                chk("rf_waddr", 64'(rf_waddr), 64'(exp_q[0].rd));
                chk("rf_wdata", 64'(rf_wdata), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                chk("rf_wen_idle", 64'(rf_wen), 64'd0);
                chk("rf_waddr_idle", 64'(rf_waddr), 64'd0);
                chk("rf_wdata_idle", 64'(rf_wdata), 64'd0);
            end
        end else begin
            model_cnt = 0;
        end
    end

    // One cycle of stimulus; ready is predicted from the occupancy seen at the last edge.
    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                         input logic [AW-1:0] c1, input logic [AW-1:0] c2);
        logic full, exp_l, exp_a;
        @(negedge clk);
        #1;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        chk_rs1 = c1; chk_rs2 = c2;
        #1;
        full  = (model_cnt == DEPTH);
        exp_l = lv & ~full;
        exp_a = av & ~full & ~lv;
        chk("lsu_ready", 64'(lsu_ready), 64'(exp_l));
        chk("alu_ready", 64'(alu_ready), 64'(exp_a));
        if (exp_l && lrd != 0) begin
            exp_q.push_back('{rd: lrd, data: ld});
            last_rd = lrd;
        end else if (exp_a && ard != 0) begin
            exp_q.push_back('{rd: ard, data: ad});
            last_rd = ard;
        end
    endtask

    task automatic idle(input logic [AW-1:0] c1);
        drive(1'b0, '0, '0, 1'b0, '0, '0, c1, '0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; model_cnt = 0; last_rd = '0;
        rst = 1'b0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
        chk_rs1 = 5'd5; chk_rs2 = 5'd3;
        repeat (2) @(negedge clk);
        // Reset state: outputs quiet, ready follows valid with full = 0.
        alu_valid = 1'b1; alu_rd = 5'd5;
        #1;
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_busy1", 64'(busy_rs1), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        alu_valid = 1'b0;
        #2 rst = 1'b1;

        // Single ALU result.
        drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, 5'd5, '0);
        idle(5'd5);
        idle(5'd5);

        // Arbitration: LSU first, ALU retried next cycle.
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd4, 5'd3);
        drive(1'b1, 5'd3, 32'hA, 1'b0, '0, '0, 5'd4, 5'd3);
        idle(5'd3);
        idle('0);

        // x0 discard.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 5'd0, 5'd0);
        idle(5'd0);

        // Sustained LSU stream.
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b0, '0, '0, 1'b1, 5'(10 + i), 32'(32'hC0 + i), 5'(10 + i), 5'(9 + i));
        end
        idle(5'd15);
        idle('0);

        // WAW on x7.
        drive(1'b1, 5'd7, 32'd1, 1'b0, '0, '0, 5'd7, '0);
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'd2, 5'd7, '0);
        idle(5'd7);
        idle(5'd7);

        // Reset mid-operation with writes pending.
        drive(1'b1, 5'd1, 32'h11, 1'b0, '0, '0, 5'd1, 5'd2);
        drive(1'b0, '0, '0, 1'b1, 5'd2, 32'h22, 5'd2, 5'd1);
        @(posedge clk);
        #2;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_busy1", 64'(busy_rs1), 64'd0);
        chk("mid_rst_busy2", 64'(busy_rs2), 64'd0);
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        #3 rst = 1'b1;
        idle(5'd2);
        drive(1'b1, 5'd9, 32'h55, 1'b0, '0, '0, 5'd9, '0);
        idle(5'd9);
        idle('0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
                  last_rd, 5'($urandom_range(0, 31)));
        end
        repeat (3) idle('0);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
